lsu_mem_port: RTL and testbench

- Memory-side responder for the core's LOAD_OP/STORE_OP requests.
- Accepts one decoded load/store per handshake, validates alignment, issues a word-aligned byte-enabled access to data memory, then waits for completion.
- Returns sign- or zero-extended load data, or a store acknowledge, to the writeback stage.
- Sits between the execute stage and the data memory/bus. One transaction is outstanding at a time.

---
 rtl/lsu_mem_port_pkg.sv | 46 ++++
 rtl/lsu_load_extend.sv | 25 ++
 rtl/lsu_mem_port.sv | 131 +++++++++++++
 tb/tb_lsu_mem_port.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// Shared types and constants for the LSU memory port: funct3 encodings, byte-enable
// patterns, FSM state type and request decode helpers.
package lsu_mem_port_pkg;

  localparam logic [2:0] LS_BYTE  = 3'b000;
  localparam logic [2:0] LS_HALF  = 3'b001;
  localparam logic [2:0] LS_WORD  = 3'b010;
  localparam logic [2:0] LS_UBYTE = 3'b100;
  localparam logic [2:0] LS_UHALF = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

  function automatic logic ls_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] lane);
    case (funct3)
      LS_BYTE:  return 1'b1;
      LS_HALF:  return !lane[0];
      LS_WORD:  return lane == 2'b00;
      LS_UBYTE: return !we;
      LS_UHALF: return !we && !lane[0];
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ls_be(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      LS_BYTE, LS_UBYTE: return BE_BYTE << lane;
      LS_HALF, LS_UHALF: return BE_HALF << lane;
      default:           return BE_WORD;
    endcase
  endfunction

  // Replicate store data into every lane so the byte enables alone select the target.
  function automatic logic [31:0] ls_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      LS_BYTE, LS_UBYTE: return {4{wdata[7:0]}};
      LS_HALF, LS_UHALF: return {2{wdata[15:0]}};
      default:           return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/half lane of a memory read word and sign- or
// zero-extends it according to funct3.
module lsu_load_extend
  import lsu_mem_port_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata >> {addr, 3'b000};
    case (funct3)
      LS_BYTE:  result = {{24{lane[7]}}, lane[7:0]};
      LS_HALF:  result = {{16{lane[15]}}, lane[15:0]};
      LS_UBYTE: result = {24'b0, lane[7:0]};
      LS_UHALF: result = {16'b0, lane[15:0]};
      default:  result = lane;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU memory-side responder: one outstanding word-aligned byte-enabled access.
// Optional abort of stuck accesses when LSU_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | mem_req held until mem_gnt
// WAIT  | granted, waiting for mem_rvalid
// RESP  | response held until resp_ready
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t  state, state_nxt;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] load_ext;
  logic        accept, legal, timeout;

  assign accept = req_valid && req_ready;
  assign legal  = ls_legal(req_we, req_funct3, req_addr[1:0]);

  lsu_load_extend u_load_extend (
    .funct3 (funct3_q),
    .addr   (lane_q),
    .rdata  (mem_rdata),
    .result (load_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              to_cnt <= '0;
    else if (accept)                         to_cnt <= '0;
    else if (state == ISSUE || state == WAIT) to_cnt <= to_cnt + 1'b1;
  end

  // to_cnt counts completed busy cycles, so abort in the cycle that completes the budget.
  assign timeout = (state == ISSUE || state == WAIT) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = legal ? ISSUE : RESP;
      ISSUE: if (timeout) state_nxt = RESP;
             else if (mem_gnt) state_nxt = WAIT;
      WAIT:  if (timeout || mem_rvalid) state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE:    req_ready  = 1'b1;
      ISSUE:   mem_req    = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q   <= '0;
      lane_q     <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rd    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      funct3_q   <= req_funct3;
      lane_q     <= req_addr[1:0];
      mem_we     <= req_we;
      mem_be     <= ls_be(req_funct3, req_addr[1:0]);
      mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
      mem_wdata  <= ls_wdata(req_funct3, req_wdata);
      resp_rd    <= req_rd;
      resp_rdata <= '0;
      resp_err   <= !legal;
    end else if (timeout) begin
      resp_rdata <= '0;
      resp_err   <= 1'b1;
    end else if (state == WAIT && mem_rvalid) begin
      resp_rdata <= mem_we ? 32'b0 : load_ext;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port; the timeout scenario is built
// only when LSU_TIMEOUT_EN is defined (with TIMEOUT_CYCLES overridden to 4).
module tb_lsu_mem_port;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total  = 0;
  int passed = 0;

  lsu_mem_port #(
    .ADDR_W(32)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b want 0", mem_req); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
    total++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'b0) $display("FAIL rst_mem_fields got %h want 0", {mem_we, mem_be, mem_addr, mem_wdata}); else passed++;
    total++; if ({resp_rdata, resp_rd, resp_err} !== 38'b0) $display("FAIL rst_resp_fields got %h want 0", {resp_rdata, resp_rd, resp_err}); else passed++;
    #6 rst_n = 1'b1;
    step();
  endtask

  // Legal access with immediate grant and rvalid one cycle later; accept is cycle 0.
  task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFFC;
    drive_req(we, f3, addr, wdata, rd);
    total++; if (req_ready !== 1'b1) $display("FAIL %s_c0_ready got %b want 1", tag, req_ready); else passed++;
    step();
    req_valid = 1'b0;
    total++; if (mem_req !== 1'b1) $display("FAIL %s_c1_mem_req got %b want 1", tag, mem_req); else passed++;
    total++; if (mem_we !== we) $display("FAIL %s_mem_we got %b want %b", tag, mem_we, we); else passed++;
    total++; if (mem_be !== exp_be) $display("FAIL %s_mem_be got %b want %b", tag, mem_be, exp_be); else passed++;
    total++; if (mem_addr !== exp_addr) $display("FAIL %s_mem_addr got %h want %h", tag, mem_addr, exp_addr); else passed++;
    total++; if (mem_wdata !== exp_wdata) $display("FAIL %s_mem_wdata got %h want %h", tag, mem_wdata, exp_wdata); else passed++;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    total++; if ({mem_req, resp_valid} !== 2'b00) $display("FAIL %s_c2_wait got %b want 00", tag, {mem_req, resp_valid}); else passed++;
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    total++; if (resp_valid !== 1'b1) $display("FAIL %s_c3_resp_valid got %b want 1", tag, resp_valid); else passed++;
    total++; if (resp_rdata !== exp_rdata) $display("FAIL %s_resp_rdata got %h want %h", tag, resp_rdata, exp_rdata); else passed++;
    total++; if ({resp_err, resp_rd} !== {1'b0, rd}) $display("FAIL %s_resp_err_rd got %h want %h", tag, {resp_err, resp_rd}, {1'b0, rd}); else passed++;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    total++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL %s_back_idle got %b want 10", tag, {req_ready, resp_valid}); else passed++;
  endtask

  task automatic test_loads();
    run_access("lb",  1'b0, 3'b000, 32'h103, 32'h0, 5'd5,  32'h80FF_1234, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_access("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 5'd6,  32'hBEEF_0000, 4'b1100, 32'h0, 32'h0000_BEEF);
    run_access("lh",  1'b0, 3'b001, 32'h006, 32'h0, 5'd7,  32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
    run_access("lbu", 1'b0, 3'b100, 32'h501, 32'h0, 5'd8,  32'h0000_9A00, 4'b0010, 32'h0, 32'h0000_009A);
    run_access("lw",  1'b0, 3'b010, 32'h408, 32'h0, 5'd31, 32'h1234_5678, 4'b1111, 32'h0, 32'h1234_5678);
  endtask

  task automatic test_stores();
    run_access("sb", 1'b1, 3'b000, 32'h301, 32'h1234_56AB, 5'd1, 32'hDEAD_BEEF, 4'b0010, 32'hABAB_ABAB, 32'h0);
    run_access("sh", 1'b1, 3'b001, 32'h002, 32'h0000_CAFE, 5'd2, 32'hDEAD_BEEF, 4'b1100, 32'hCAFE_CAFE, 32'h0);
    run_access("sw", 1'b1, 3'b010, 32'h7FC, 32'h89AB_CDEF, 5'd3, 32'hDEAD_BEEF, 4'b1111, 32'h89AB_CDEF, 32'h0);
  endtask

  task automatic test_illegal();
    logic        we_v [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_v [5] = '{3'b010, 3'b101, 3'b011, 3'b001, 3'b100};
    logic [31:0] ad_v [5] = '{32'h402, 32'h000, 32'h000, 32'h001, 32'h000};
    for (int i = 0; i < 5; i++) begin
      drive_req(we_v[i], f3_v[i], ad_v[i], 32'hFFFF_FFFF, 5'(i + 10));
      step();
      req_valid = 1'b0;
      total++; if (mem_req !== 1'b0) $display("FAIL ill%0d_mem_req got %b want 0", i, mem_req); else passed++;
      total++; if ({resp_valid, resp_err} !== 2'b11) $display("FAIL ill%0d_c1_resp got %b want 11", i, {resp_valid, resp_err}); else passed++;
      total++; if ({resp_rdata, resp_rd} !== {32'h0, 5'(i + 10)}) $display("FAIL ill%0d_rdata_rd got %h want %h", i, {resp_rdata, resp_rd}, {32'h0, 5'(i + 10)}); else passed++;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      total++; if ({req_ready, mem_req} !== 2'b10) $display("FAIL ill%0d_back_idle got %b want 10", i, {req_ready, mem_req}); else passed++;
    end
  endtask

  task automatic test_gnt_rvalid_same();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    total++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL idle_rvalid got %b want 10", {req_ready, resp_valid}); else passed++;
    mem_rvalid = 1'b0;
    drive_req(1'b0, 3'b100, 32'h11, 32'h0, 5'd4);
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    total++; if ({mem_req, resp_valid} !== 2'b00) $display("FAIL same_cyc_wait got %b want 00", {mem_req, resp_valid}); else passed++;
    step();
    total++; if (resp_valid !== 1'b0) $display("FAIL same_cyc_still_wait got %b want 0", resp_valid); else passed++;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_7F00;
    step();
    mem_rvalid = 1'b0;
    total++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h0000_007F}) $display("FAIL same_cyc_resp got %h want %h", {resp_valid, resp_rdata}, {1'b1, 32'h0000_007F}); else passed++;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_stall();
    drive_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd9);
    step();
    drive_req(1'b1, 3'b000, 32'hFFF0, 32'hFFFF_FFFF, 5'd0);
    for (int i = 0; i < 5; i++) begin
      total++; if ({mem_req, req_ready, mem_we, mem_be, mem_addr} !== {3'b100, 4'b1111, 32'h10}) $display("FAIL stall_issue%0d got %h want %h", i, {mem_req, req_ready, mem_we, mem_be, mem_addr}, {3'b100, 4'b1111, 32'h10}); else passed++;
      step();
    end
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    total++; if (mem_req !== 1'b1) $display("FAIL stall_gnt_cycle got %b want 1", mem_req); else passed++;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    drive_req(1'b0, 3'b000, 32'h44, 32'h0, 5'd1);
    for (int i = 0; i < 4; i++) begin
      total++; if ({resp_valid, req_ready, resp_err, resp_rd, resp_rdata} !== {3'b100, 5'd9, 32'hCAFE_F00D}) $display("FAIL stall_resp%0d got %h want %h", i, {resp_valid, req_ready, resp_err, resp_rd, resp_rdata}, {3'b100, 5'd9, 32'hCAFE_F00D}); else passed++;
      if (i < 3) step();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    total++; if ({req_ready, mem_req, resp_valid} !== 3'b100) $display("FAIL stall_release got %b want 100", {req_ready, mem_req, resp_valid}); else passed++;
  endtask

  task automatic test_reset_mid();
    drive_req(1'b1, 3'b010, 32'h20, 32'h55, 5'd2);
    step();
    req_valid = 1'b0;
    total++; if (mem_req !== 1'b1) $display("FAIL rmid_issue got %b want 1", mem_req); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({mem_req, req_ready, mem_we, mem_be} !== 7'b0100000) $display("FAIL rmid_issue_rst got %b want 0100000", {mem_req, req_ready, mem_we, mem_be}); else passed++;
    #1 rst_n = 1'b1;
    step();
    drive_req(1'b0, 3'b010, 32'h24, 32'h0, 5'd3);
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if ({mem_req, req_ready, resp_valid} !== 3'b010) $display("FAIL rmid_wait_rst got %b want 010", {mem_req, req_ready, resp_valid}); else passed++;
    #1 rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    total++; if ({req_ready, resp_valid, resp_rdata} !== {2'b10, 32'h0}) $display("FAIL rmid_late_rvalid got %h want %h", {req_ready, resp_valid, resp_rdata}, {2'b10, 32'h0}); else passed++;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    drive_req(1'b0, 3'b000, 32'h0, 32'h0, 5'd12);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if ({mem_req, resp_valid} !== 2'b10) $display("FAIL to_issue%0d got %b want 10", i, {mem_req, resp_valid}); else passed++;
      step();
    end
    total++; if ({mem_req, resp_valid, resp_err, resp_rdata} !== {3'b011, 32'h0}) $display("FAIL to_abort got %h want %h", {mem_req, resp_valid, resp_err, resp_rdata}, {3'b011, 32'h0}); else passed++;
    resp_ready = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    resp_ready = 1'b0;
    step();
    mem_rvalid = 1'b0;
    total++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL to_late_rvalid got %b want 10", {req_ready, resp_valid}); else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_illegal();
    test_gnt_rvalid_same();
    test_stall();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
